// File: rtl/servo_scan_sequencer_if.sv
// ----------------------------------------------------------------------------
// servo_scan_sequencer_if
// Purpose : groups the command handshake, abort, the eight servo strobes and
//           the status outputs of servo_scan_sequencer into one bundle.
// Modports:
//   master - firmware/APB side: drives cmd_valid/cmd_axis/cmd_op/cmd_periods
//            and abort; observes cmd_ready, strobes, busy, done, fifo_count.
//   slave  - the sequencer: the mirror image of master.
// Handshake: a command is transferred on a PCLK edge where cmd_valid and
//            cmd_ready are both high. cmd_ready depends only on queue fill
//            (never on cmd_valid). The master may drop or change the command
//            at any time while cmd_ready is low.
// ----------------------------------------------------------------------------
interface servo_scan_sequencer_if #(
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_axis;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_periods;
   logic             abort;
   logic             x_set_neutral;
   logic             x_set_forward;
   logic             x_set_reverse;
   logic             x_return_to_zero;
   logic             y_set_neutral;
   logic             y_set_forward;
   logic             y_set_reverse;
   logic             y_return_to_zero;
   logic             busy;
   logic             done;
   logic [CW-1:0]    fifo_count;

   modport master (
      output cmd_valid, cmd_axis, cmd_op, cmd_periods, abort,
      input  cmd_ready, x_set_neutral, x_set_forward, x_set_reverse, x_return_to_zero,
             y_set_neutral, y_set_forward, y_set_reverse, y_return_to_zero,
             busy, done, fifo_count
   );

   modport slave (
      input  cmd_valid, cmd_axis, cmd_op, cmd_periods, abort,
      output cmd_ready, x_set_neutral, x_set_forward, x_set_reverse, x_return_to_zero,
             y_set_neutral, y_set_forward, y_set_reverse, y_return_to_zero,
             busy, done, fifo_count
   );
endinterface

// File: rtl/servo_scan_sequencer.sv
// ----------------------------------------------------------------------------
// servo_scan_sequencer
// Purpose : queues timed servo commands {axis, op, periods} and replays them as
//           one-cycle strobes to the X/Y tracking servos, holding each command
//           for 'periods' PWM period ticks before moving to the next.
// Ports   :
//   PCLK      - clock
//   PRESERN   - asynchronous active-low reset
//   bus       - servo_scan_sequencer_if.slave (command handshake, abort,
//               strobes, busy, done, fifo_count)
//   dbg_state - current FSM state (0 IDLE, 1 ISSUE, 2 HOLD, 3 STOP)
// ----------------------------------------------------------------------------
module servo_scan_sequencer #(
   parameter int PWM_PERIOD = 2000000,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESERN,
   servo_scan_sequencer_if.slave bus,
   output logic [1:0]           dbg_state
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int EW = 3 + CNT_W;   // {axis, op[1:0], periods}

   localparam logic [1:0] OP_NEUTRAL = 2'd0;
   localparam logic [1:0] OP_FORWARD = 2'd1;
   localparam logic [1:0] OP_REVERSE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [EW-1:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    per_cnt_q, per_cnt_d;
   state_t           state_q, state_d;
   logic             act_axis_q, act_axis_d;
   logic [1:0]       act_op_q, act_op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             skip_q, skip_d;
   logic [1:0]       abort_neut_q, abort_neut_d;   // [0] X, [1] Y

   logic             full, empty, push, pop, tick, motion_op;
   logic [EW-1:0]    head;
   logic [7:0]       strobes;   // index {axis, op}

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign tick      = (per_cnt_q == PW'(PWM_PERIOD - 1));
   assign head      = mem_q[rd_ptr_q];
   assign motion_op = (act_op_q == OP_FORWARD) || (act_op_q == OP_REVERSE);
   // abort dominates: it blocks both queue ports in the cycle it is seen
   assign push      = bus.cmd_valid && !full && !bus.abort;
   assign pop       = (state_q == IDLE) && !empty && !bus.abort;

   // ---------------- state register ----------------
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         per_cnt_q    <= '0;
         state_q      <= IDLE;
         act_axis_q   <= 1'b0;
         act_op_q     <= OP_NEUTRAL;
         rem_q        <= '0;
         skip_q       <= 1'b0;
         abort_neut_q <= 2'b00;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         per_cnt_q    <= per_cnt_d;
         state_q      <= state_d;
         act_axis_q   <= act_axis_d;
         act_op_q     <= act_op_d;
         rem_q        <= rem_d;
         skip_q       <= skip_d;
         abort_neut_q <= abort_neut_d;
      end
   end

   // ---------------- next-state / datapath ----------------
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      per_cnt_d    = tick ? '0 : per_cnt_q + 1'b1;   // free-running, abort does not touch it
      state_d      = state_q;
      act_axis_d   = act_axis_q;
      act_op_d     = act_op_q;
      rem_d        = rem_q;
      skip_d       = 1'b0;
      abort_neut_d = 2'b00;

      if (bus.abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         state_d  = IDLE;
         // a motor left running by forward/reverse must be parked explicitly
         if ((state_q == ISSUE || state_q == HOLD) && motion_op)
            abort_neut_d[act_axis_q] = 1'b1;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_axis, bus.cmd_op, bus.cmd_periods};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase

         case (state_q)
            IDLE: begin
               if (pop) begin
                  // the duration is loaded straight into the hold counter
                  act_axis_d = head[EW-1];
                  act_op_d   = head[EW-2 -: 2];
                  rem_d      = head[CNT_W-1:0];
                  if (head[CNT_W-1:0] == '0) skip_d  = 1'b1;
                  else                       state_d = ISSUE;
               end
            end
            ISSUE: state_d = HOLD;
            HOLD: begin
               if (tick) begin
                  if (rem_q == CNT_W'(1)) state_d = STOP;
                  else                    rem_d   = rem_q - 1'b1;
               end
            end
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      strobes = 8'h00;
      case (state_q)
         ISSUE:   strobes[{act_axis_q, act_op_q}] = 1'b1;
         STOP:    if (motion_op) strobes[{act_axis_q, OP_NEUTRAL}] = 1'b1;
         default: strobes = 8'h00;
      endcase
      // abort parking strobe lands while already back in IDLE
      strobes[0] = strobes[0] | abort_neut_q[0];
      strobes[4] = strobes[4] | abort_neut_q[1];
   end

   assign bus.x_set_neutral    = strobes[0];
   assign bus.x_set_forward    = strobes[1];
   assign bus.x_set_reverse    = strobes[2];
   assign bus.x_return_to_zero = strobes[3];
   assign bus.y_set_neutral    = strobes[4];
   assign bus.y_set_forward    = strobes[5];
   assign bus.y_set_reverse    = strobes[6];
   assign bus.y_return_to_zero = strobes[7];
   assign bus.done             = (state_q == STOP) || skip_q;
   assign bus.busy             = (state_q != IDLE) || !empty;
   assign bus.cmd_ready        = !full;
   assign bus.fifo_count       = count_q;
   assign dbg_state            = state_q;
endmodule

// File: tb/tb_servo_scan_sequencer.sv
// ----------------------------------------------------------------------------
// tb_servo_scan_sequencer
// Directed and random command streams for servo_scan_sequencer. The reference
// model turns each accepted command into its expected event list (strobe
// codes and done) and predicts the exact done cycle from the PWM tick rule
// (tick on every cycle whose index since reset release is P-1 mod P).
// ----------------------------------------------------------------------------
module tb_servo_scan_sequencer;
   localparam int P     = 10;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam logic [3:0] EV_DONE = 4'd8;

   typedef struct {
      logic       axis;
      logic [1:0] op;
      int         n;
   } cmd_t;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } ev_t;

   logic       PCLK;
   logic       PRESERN;
   logic [1:0] dbg_state;
   logic [7:0] strobes_obs;

   int   cyc;
   int   checks = 0;
   int   errors = 0;
   cmd_t model_q[$];
   ev_t  obs_q[$];
   logic [3:0] exp_q[$];

   servo_scan_sequencer_if #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) bus ();

   servo_scan_sequencer #(
      .PWM_PERIOD(P),
      .FIFO_DEPTH(DEPTH),
      .CNT_W     (CNT_W)
   ) dut (
      .PCLK     (PCLK),
      .PRESERN  (PRESERN),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   assign strobes_obs = {bus.y_return_to_zero, bus.y_set_reverse, bus.y_set_forward, bus.y_set_neutral,
                         bus.x_return_to_zero, bus.x_set_reverse, bus.x_set_forward, bus.x_set_neutral};

   // ---------------- clock / reset ----------------
   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   always @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ev_code(input int k);
      return (k < obs_q.size()) ? obs_q[k].code : 4'hF;
   endfunction

   function automatic int ev_cyc(input int k);
      return (k < obs_q.size()) ? obs_q[k].cyc : -1;
   endfunction

   // Walk the model commands in order and match them against the observed events.
   task automatic check_phase(input string tag);
      int k = 0;
      int c_issue, t1, d_exp;
      foreach (model_q[i]) begin
         if (model_q[i].n == 0) begin
            check({tag, "_skip_done"}, 32'(ev_code(k)), 32'(EV_DONE));
            k++;
         end else begin
            check({tag, "_issue"}, 32'(ev_code(k)), 32'({model_q[i].axis, model_q[i].op}));
            c_issue = ev_cyc(k);
            k++;
            t1    = c_issue + 1 + (P - 1 - ((c_issue + 1) % P));
            d_exp = t1 + (model_q[i].n - 1) * P + 1;
            if (model_q[i].op == 2'd1 || model_q[i].op == 2'd2) begin
               check({tag, "_end_neutral"}, 32'(ev_code(k)), 32'({model_q[i].axis, 2'b00}));
               check({tag, "_neutral_cycle"}, 32'(ev_cyc(k)), 32'(d_exp));
               k++;
            end
            check({tag, "_done"}, 32'(ev_code(k)), 32'(EV_DONE));
            check({tag, "_done_cycle"}, 32'(ev_cyc(k)), 32'(d_exp));
            k++;
         end
      end
      check({tag, "_event_count"}, 32'(obs_q.size()), 32'(k));
   endtask

   // ---------------- monitor ----------------
   always @(negedge PCLK) begin
      if (PRESERN) begin
         check("onehot", 32'($countones(strobes_obs) <= 1), 32'd1);
         for (int i = 0; i < 8; i++)
            if (strobes_obs[i]) obs_q.push_back('{code: 4'(i), cyc: cyc});
         if (bus.done) obs_q.push_back('{code: EV_DONE, cyc: cyc});
      end
   end

   // ---------------- driver tasks (call just after a negedge) ----------------
   task automatic push_cmd(input logic ax, input logic [1:0] op, input int n, input int budget,
                           output bit acc, output int acc_cyc);
      bus.cmd_valid   = 1'b1;
      bus.cmd_axis    = ax;
      bus.cmd_op      = op;
      bus.cmd_periods = CNT_W'(n);
      acc     = 1'b0;
      acc_cyc = -1;
      for (int i = 0; i < budget && !acc; i++) begin
         if (bus.cmd_ready) begin
            acc     = 1'b1;
            acc_cyc = cyc;
         end
         @(negedge PCLK);
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      repeat (3) @(negedge PCLK);
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (!bus.busy) ok = 1'b1;
         else           @(negedge PCLK);
      end
      check({tag, "_idle"}, 32'(ok), 32'd1);
      repeat (3) @(negedge PCLK);
   endtask

   task automatic new_phase();
      obs_q.delete();
      model_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit acc;
      int a;
      logic       r_ax;
      logic [1:0] r_op;
      int         r_n;

      bus.cmd_valid   = 1'b0;
      bus.cmd_axis    = 1'b0;
      bus.cmd_op      = 2'd0;
      bus.cmd_periods = '0;
      bus.abort       = 1'b0;
      PRESERN         = 1'b0;

      repeat (3) @(negedge PCLK);
      check("rst_in_strobes", strobes_obs, 0);
      check("rst_in_ready", bus.cmd_ready, 1);
      check("rst_in_busy", bus.busy, 0);
      new_phase();
      #2 PRESERN = 1'b1;
      @(negedge PCLK);
      check("rst_strobes", strobes_obs, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_count", bus.fifo_count, 0);
      check("rst_state", dbg_state, 0);
      repeat (4) @(negedge PCLK);

      // T1: single X forward, 3 periods
      push_cmd(1'b0, 2'd1, 3, 4, acc, a);
      check("t1_accept", 32'(acc), 1);
      model_q.push_back('{axis: 1'b0, op: 2'd1, n: 3});
      check("t1_no_early_strobe", strobes_obs, 0);
      @(negedge PCLK);
      check("t1_fwd_cycle", 32'(cyc), 32'(a + 2));
      check("t1_fwd_strobe", strobes_obs, 8'h02);
      acc = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge PCLK);
         if (bus.done) acc = 1'b1;
      end
      check("t1_done_seen", 32'(acc), 1);
      check("t1_busy_at_done", bus.busy, 1);
      check("t1_neutral_with_done", strobes_obs, 8'h01);
      @(negedge PCLK);
      check("t1_busy_after", bus.busy, 0);
      wait_idle("t1");
      check_phase("t1");

      // T2: three back-to-back commands
      new_phase();
      push_cmd(1'b1, 2'd2, 1, 4, acc, a);
      check("t2_acc0", 32'(acc), 1);
      model_q.push_back('{axis: 1'b1, op: 2'd2, n: 1});
      push_cmd(1'b0, 2'd3, 2, 4, acc, a);
      check("t2_acc1", 32'(acc), 1);
      model_q.push_back('{axis: 1'b0, op: 2'd3, n: 2});
      push_cmd(1'b1, 2'd0, 1, 4, acc, a);
      check("t2_acc2", 32'(acc), 1);
      model_q.push_back('{axis: 1'b1, op: 2'd0, n: 1});
      wait_idle("t2");
      check_phase("t2");

      // T3: fill the queue behind a long command
      new_phase();
      push_cmd(1'b0, 2'd1, 4, 4, acc, a);
      model_q.push_back('{axis: 1'b0, op: 2'd1, n: 4});
      repeat (4) @(negedge PCLK);
      push_cmd(1'b1, 2'd1, 1, 2, acc, a);
      check("t3_acc0", 32'(acc), 1);
      model_q.push_back('{axis: 1'b1, op: 2'd1, n: 1});
      push_cmd(1'b0, 2'd2, 1, 2, acc, a);
      check("t3_acc1", 32'(acc), 1);
      model_q.push_back('{axis: 1'b0, op: 2'd2, n: 1});
      push_cmd(1'b1, 2'd3, 1, 2, acc, a);
      check("t3_acc2", 32'(acc), 1);
      model_q.push_back('{axis: 1'b1, op: 2'd3, n: 1});
      push_cmd(1'b0, 2'd0, 1, 2, acc, a);
      check("t3_acc3", 32'(acc), 1);
      model_q.push_back('{axis: 1'b0, op: 2'd0, n: 1});
      check("t3_count_full", bus.fifo_count, 4);
      check("t3_ready_low", bus.cmd_ready, 0);
      push_cmd(1'b1, 2'd2, 2, 1, acc, a);
      check("t3_fifth_rejected", 32'(acc), 0);
      check("t3_count_still_full", bus.fifo_count, 4);
      wait_idle("t3");
      check_phase("t3");

      // T4: zero-duration command is skipped
      new_phase();
      push_cmd(1'b0, 2'd1, 0, 4, acc, a);
      model_q.push_back('{axis: 1'b0, op: 2'd1, n: 0});
      check("t4_no_done_at_pop", bus.done, 0);
      @(negedge PCLK);
      check("t4_done", bus.done, 1);
      check("t4_no_strobe", strobes_obs, 0);
      check("t4_busy", bus.busy, 0);
      check("t4_state_idle", dbg_state, 0);
      wait_idle("t4");
      check_phase("t4");

      // T5: abort mid-HOLD with two queued
      new_phase();
      push_cmd(1'b1, 2'd1, 5, 4, acc, a);
      push_cmd(1'b0, 2'd2, 1, 4, acc, a);
      push_cmd(1'b1, 2'd3, 2, 4, acc, a);
      repeat (10) @(negedge PCLK);
      check("t5_count_before", bus.fifo_count, 2);
      bus.abort = 1'b1;
      @(negedge PCLK);
      bus.abort = 1'b0;
      check("t5_neutral", strobes_obs, 8'h10);
      check("t5_count", bus.fifo_count, 0);
      check("t5_no_done", bus.done, 0);
      check("t5_busy", bus.busy, 0);
      repeat (80) @(negedge PCLK);
      exp_q = '{4'd5, 4'd4};
      check("t5_event_count", 32'(obs_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) check("t5_event", 32'(ev_code(i)), 32'(exp_q[i]));

      // T6: random command stream
      new_phase();
      for (int i = 0; i < 12; i++) begin
         r_ax = 1'($urandom_range(0, 1));
         r_op = 2'($urandom_range(0, 3));
         r_n  = int'($urandom_range(0, 3));
         push_cmd(r_ax, r_op, r_n, 400, acc, a);
         check("t6_accept", 32'(acc), 1);
         if (acc) model_q.push_back('{axis: r_ax, op: r_op, n: r_n});
         repeat ($urandom_range(0, 6)) @(negedge PCLK);
      end
      wait_idle("t6");
      check_phase("t6");

      // T7: reset while a strobe is high and one command is queued
      new_phase();
      push_cmd(1'b0, 2'd2, 3, 4, acc, a);
      push_cmd(1'b1, 2'd1, 1, 4, acc, a);
      check("t7_rev_strobe", strobes_obs, 8'h04);
      check("t7_count", bus.fifo_count, 1);
      #2 PRESERN = 1'b0;
      #1;
      check("t7_async_strobes", strobes_obs, 0);
      check("t7_async_busy", bus.busy, 0);
      check("t7_async_done", bus.done, 0);
      check("t7_async_count", bus.fifo_count, 0);
      check("t7_async_ready", bus.cmd_ready, 1);
      check("t7_events_before", 32'(obs_q.size()), 1);
      check("t7_event_code", 32'(ev_code(0)), 32'd2);
      new_phase();
      @(negedge PCLK);
      #2 PRESERN = 1'b1;
      @(negedge PCLK);
      check("t7_ready_after", bus.cmd_ready, 1);
      check("t7_count_after", bus.fifo_count, 0);
      check("t7_busy_after", bus.busy, 0);
      push_cmd(1'b1, 2'd2, 1, 4, acc, a);
      model_q.push_back('{axis: 1'b1, op: 2'd2, n: 1});
      wait_idle("t7");
      check_phase("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
